trap_controller: RTL and testbench

- Sequences entry into machine-mode traps for the 5-stage core.
- Sources: synchronous exceptions from decode (illegal instruction, ecall, ebreak) and asynchronous machine interrupts (software, timer, external).
- Prioritises the sources, waits for the memory stage to drain, then issues a single-cycle trap commit: exception, cause, epc, target and flush vector.
- Sits between the decode/execute pipeline registers and the CSR file, and replaces the combinational exception decision.

---
 rtl/trap_controller_pkg.sv | 28 ++
 rtl/trap_controller_if.sv | 30 +++
 rtl/trap_sync.sv | 22 ++
 rtl/trap_controller.sv | 133 +++++++++++++
 tb/tb_trap_controller.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/trap_controller_pkg.sv
// Shared types and cause encodings for the machine-mode trap sequencer.
package trap_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } trap_state_t;

  localparam int INTERRUPT_BIT = 31;

  localparam logic [31:0] CAUSE_ILLEGAL_INST = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  function automatic logic [31:0] irq_cause(input logic [4:0] code);
    logic [31:0] c;
    c                = '0;
    c[INTERRUPT_BIT] = 1'b1;
    c[4:0]           = code;
    return c;
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Signal bundle for the trap controller, with DUT-side and bench-side views.
interface trap_controller_if (input logic CLK);
  logic        nRST;
  logic        illegal_inst, ecall, ebreak;
  logic [31:0] e2mif_pc;
  logic        e2mif_valid, dmem_busy;
  logic        msip_i, mtip_i, meip_i;
  logic        interrupt_en;
  logic [2:0]  mie_i;
  logic [1:0]  mtvec_mode;
  logic [31:0] mtvec_base;
  logic        mtvec_valid_i;
  logic        hold, exception, is_interrupt;
  logic [31:0] exception_cause, exception_pc, exception_target;
  logic        f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush;

  modport trap_controller (
    input  CLK, nRST, illegal_inst, ecall, ebreak, e2mif_pc, e2mif_valid, dmem_busy,
           msip_i, mtip_i, meip_i, interrupt_en, mie_i, mtvec_mode, mtvec_base, mtvec_valid_i,
    output hold, exception, is_interrupt, exception_cause, exception_pc, exception_target,
           f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush
  );

  modport tb (
    input  CLK, hold, exception, is_interrupt, exception_cause, exception_pc, exception_target,
           f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush,
    output nRST, illegal_inst, ecall, ebreak, e2mif_pc, e2mif_valid, dmem_busy,
           msip_i, mtip_i, meip_i, interrupt_en, mie_i, mtvec_mode, mtvec_base, mtvec_valid_i
  );
endinterface

// File: rtl/trap_sync.sv
// Reset-to-zero flop chain bringing the asynchronous external interrupt into CLK.
module trap_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic async_i,
  output logic sync_o
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry sequencer: prioritise, drain the memory stage, commit once.
// Optional vectored interrupt targets are enabled with TRAP_VECTORED_EN.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        illegal_inst,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic [31:0] e2mif_pc,
  input  logic        e2mif_valid,
  input  logic        dmem_busy,
  input  logic        msip_i,
  input  logic        mtip_i,
  input  logic        meip_i,
  input  logic        interrupt_en,
  input  logic [2:0]  mie_i,
  input  logic [1:0]  mtvec_mode,
  input  logic [31:0] mtvec_base,
  input  logic        mtvec_valid_i,
  output logic        hold,
  output logic        exception,
  output logic        is_interrupt,
  output logic [31:0] exception_cause,
  output logic [31:0] exception_pc,
  output logic [31:0] exception_target,
  output logic        f2dif_flush,
  output logic        d2eif_flush,
  output logic        e2mif_flush,
  output logic        m2wif_flush
);
  logic        meip_sync;
  trap_state_t state_q;
  logic        post_commit_q, exc_q, is_int_q;
  logic [31:0] cause_q, epc_q, target_q;
  logic [2:0]  irq_pend;
  logic        irq_ok, evt, is_int_d;
  logic [31:0] cause_d, target_d;

  trap_sync #(.SYNC_STAGES(SYNC_STAGES)) u_meip_sync (
    .CLK    (CLK),
    .nRST   (nRST),
    .async_i(meip_i),
    .sync_o (meip_sync)
  );

  // The CSR file clears MIE on the strobe one cycle late, so mask interrupts for that cycle.
  always_comb begin
    irq_pend = {meip_sync & mie_i[2], mtip_i & mie_i[1], msip_i & mie_i[0]};
    irq_ok   = interrupt_en & e2mif_valid & ~post_commit_q;
    evt      = 1'b1;
    is_int_d = 1'b0;
    cause_d  = '0;
    if (illegal_inst)               cause_d = CAUSE_ILLEGAL_INST;
    else if (ebreak)                cause_d = CAUSE_BREAKPOINT;
    else if (ecall)                 cause_d = CAUSE_ECALL_M;
    else if (irq_ok && irq_pend[2]) begin cause_d = irq_cause(IRQ_MEI); is_int_d = 1'b1; end
    else if (irq_ok && irq_pend[0]) begin cause_d = irq_cause(IRQ_MSI); is_int_d = 1'b1; end
    else if (irq_ok && irq_pend[1]) begin cause_d = irq_cause(IRQ_MTI); is_int_d = 1'b1; end
    else                            evt = 1'b0;
  end

`ifdef TRAP_VECTORED_EN
  always_comb begin
    target_d = mtvec_base;
    if (!mtvec_valid_i)                         target_d = RESET_VECTOR;
    else if (is_int_d && mtvec_mode == 2'd1)    target_d = mtvec_base + {25'd0, cause_d[4:0], 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = ^mtvec_mode;
  assign target_d    = mtvec_valid_i ? mtvec_base : RESET_VECTOR;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      post_commit_q <= 1'b0;
      exc_q         <= 1'b0;
      is_int_q      <= 1'b0;
      cause_q       <= '0;
      epc_q         <= '0;
      target_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          post_commit_q <= 1'b0;
          if (evt) begin
            cause_q  <= cause_d;
            is_int_q <= is_int_d;
            epc_q    <= e2mif_pc;
            target_q <= target_d;
            if (dmem_busy) state_q <= DRAIN;
            else begin
              state_q <= COMMIT;
              exc_q   <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!dmem_busy) begin
            state_q <= COMMIT;
            exc_q   <= 1'b1;
          end
        end
        COMMIT: begin
          state_q       <= IDLE;
          exc_q         <= 1'b0;
          post_commit_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          exc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign hold             = (state_q == IDLE) ? evt : 1'b1;
  assign exception        = exc_q;
  assign is_interrupt     = exc_q & is_int_q;
  assign exception_cause  = exc_q ? cause_q  : '0;
  assign exception_pc     = exc_q ? epc_q    : '0;
  assign exception_target = exc_q ? target_q : '0;
  assign f2dif_flush      = exc_q;
  assign d2eif_flush      = exc_q;
  assign e2mif_flush      = exc_q;
  assign m2wif_flush      = exc_q;
endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized trials
// compared against a priority-table reference model.
module tb_trap_controller;
  localparam int          SYNC = 2;
  localparam logic [31:0] RV   = 32'h0000_0400;

  logic clk;
  int   errors = 0;
  int   checks = 0;

  trap_controller_if ifc (.CLK(clk));

  trap_controller #(.SYNC_STAGES(SYNC), .RESET_VECTOR(RV)) dut (
    .CLK(ifc.CLK), .nRST(ifc.nRST), .illegal_inst(ifc.illegal_inst), .ecall(ifc.ecall),
    .ebreak(ifc.ebreak), .e2mif_pc(ifc.e2mif_pc), .e2mif_valid(ifc.e2mif_valid),
    .dmem_busy(ifc.dmem_busy), .msip_i(ifc.msip_i), .mtip_i(ifc.mtip_i), .meip_i(ifc.meip_i),
    .interrupt_en(ifc.interrupt_en), .mie_i(ifc.mie_i), .mtvec_mode(ifc.mtvec_mode),
    .mtvec_base(ifc.mtvec_base), .mtvec_valid_i(ifc.mtvec_valid_i), .hold(ifc.hold),
    .exception(ifc.exception), .is_interrupt(ifc.is_interrupt),
    .exception_cause(ifc.exception_cause), .exception_pc(ifc.exception_pc),
    .exception_target(ifc.exception_target), .f2dif_flush(ifc.f2dif_flush),
    .d2eif_flush(ifc.d2eif_flush), .e2mif_flush(ifc.e2mif_flush), .m2wif_flush(ifc.m2wif_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          illegal, ebreak, ecall, msip, mtip, en, valid, mvalid;
    bit [2:0]    mie;
    bit [1:0]    mode;
    logic [31:0] pc, base;
  } trial_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the priority table, first asserted source wins.
  function automatic void ref_pick(input trial_t t, output bit found, output logic [31:0] cause);
    bit          irq_ok;
    bit          cond [6];
    logic [31:0] code [6];
    irq_ok = t.en && t.valid;
    cond = '{t.illegal, t.ebreak, t.ecall, 1'b0, irq_ok && t.msip && t.mie[0], irq_ok && t.mtip && t.mie[1]};
    code = '{32'd2, 32'd3, 32'd11, 32'h8000_000B, 32'h8000_0003, 32'h8000_0007};
    found = 1'b0;
    cause = '0;
    for (int i = 0; i < 6; i++) begin
      if (cond[i] && !found) begin
        found = 1'b1;
        cause = code[i];
      end
    end
  endfunction

  function automatic logic [31:0] ref_target(input trial_t t, input logic [31:0] cause);
    if (!t.mvalid) return RV;
`ifdef TRAP_VECTORED_EN
    if (t.mode == 2'd1 && cause[31]) return t.base + (cause % 32) * 4;
`endif
    return t.base;
  endfunction

  task automatic apply(input trial_t t);
    ifc.illegal_inst  = t.illegal;  ifc.ebreak = t.ebreak; ifc.ecall = t.ecall;
    ifc.msip_i        = t.msip;     ifc.mtip_i = t.mtip;   ifc.mie_i = t.mie;
    ifc.interrupt_en  = t.en;       ifc.e2mif_valid = t.valid;
    ifc.e2mif_pc      = t.pc;       ifc.mtvec_base = t.base;
    ifc.mtvec_valid_i = t.mvalid;   ifc.mtvec_mode = t.mode;
  endtask

  task automatic clear_events(input bit keep_irq);
    ifc.illegal_inst = 0; ifc.ebreak = 0; ifc.ecall = 0;
    if (!keep_irq) begin ifc.msip_i = 0; ifc.mtip_i = 0; end
    ifc.e2mif_pc = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic run_trial(input trial_t t, input int n_busy, input bit keep_irq, input string tag);
    bit          found;
    logic [31:0] cause, tgt;
    ref_pick(t, found, cause);
    tgt = ref_target(t, cause);
    apply(t);
    ifc.dmem_busy = (n_busy > 0);
    #1;
    check({tag, ".detect_hold"}, {31'd0, ifc.hold}, {31'd0, found});
    check({tag, ".detect_exc"}, {31'd0, ifc.exception}, 32'd0);
    if (!found) begin
      tick(); clear_events(keep_irq); ifc.dmem_busy = 0; #1;
      check({tag, ".none_exc"}, {31'd0, ifc.exception}, 32'd0);
      tick();
      return;
    end
    for (int i = 1; i <= n_busy; i++) begin
      tick(); clear_events(keep_irq); ifc.dmem_busy = (i < n_busy); #1;
      check({tag, ".drain_hold"}, {31'd0, ifc.hold}, 32'd1);
      check({tag, ".drain_exc"}, {31'd0, ifc.exception}, 32'd0);
    end
    tick(); clear_events(keep_irq); ifc.dmem_busy = 0; #1;
    check({tag, ".exc"}, {31'd0, ifc.exception}, 32'd1);
    check({tag, ".cause"}, ifc.exception_cause, cause);
    check({tag, ".epc"}, ifc.exception_pc, t.pc);
    check({tag, ".target"}, ifc.exception_target, tgt);
    check({tag, ".is_int"}, {31'd0, ifc.is_interrupt}, {31'd0, cause[31]});
    check({tag, ".flush"}, {28'd0, ifc.f2dif_flush, ifc.d2eif_flush, ifc.e2mif_flush, ifc.m2wif_flush}, 32'hF);
    check({tag, ".commit_hold"}, {31'd0, ifc.hold}, 32'd1);
    tick(); #1;
    check({tag, ".after_exc"}, {31'd0, ifc.exception}, 32'd0);
    check({tag, ".after_hold"}, {31'd0, ifc.hold}, 32'd0);
    tick();
  endtask

  function automatic trial_t blank();
    trial_t t;
    t = '{illegal: 0, ebreak: 0, ecall: 0, msip: 0, mtip: 0, en: 0, valid: 0, mvalid: 0,
          mie: 3'b000, mode: 2'd0, pc: 32'd0, base: 32'd0};
    return t;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".ctl"}, {26'd0, ifc.hold, ifc.exception, ifc.is_interrupt, ifc.f2dif_flush,
          ifc.d2eif_flush, ifc.e2mif_flush, ifc.m2wif_flush} >> 0, 32'd0);
    check({tag, ".cause"}, ifc.exception_cause, 32'd0);
    check({tag, ".pc"}, ifc.exception_pc, 32'd0);
    check({tag, ".target"}, ifc.exception_target, 32'd0);
  endtask

  initial begin
    trial_t t;
    ifc.nRST = 0;
    apply(blank());
    ifc.meip_i = 0; ifc.dmem_busy = 0;
    tick(); tick();
    check_all_zero("reset");
    #2 ifc.nRST = 1;
    tick(); #1;
    check_all_zero("post_reset");

    // Illegal instruction, no drain.
    t = blank(); t.illegal = 1; t.pc = 32'h100; t.base = 32'h800; t.mvalid = 1;
    run_trial(t, 0, 0, "illegal");

    // Timer interrupt with three busy cycles.
    t = blank(); t.mtip = 1; t.mie = 3'b010; t.en = 1; t.valid = 1; t.pc = 32'h240;
    t.base = 32'h800; t.mvalid = 1;
    run_trial(t, 3, 0, "mti_drain");

    // Exception beats simultaneous MSI; MSI commits after the masked cycle.
    t = blank(); t.illegal = 1; t.msip = 1; t.mie = 3'b001; t.en = 1; t.valid = 1;
    t.pc = 32'h400; t.base = 32'h900; t.mvalid = 1;
    run_trial(t, 0, 1, "ill_vs_msi");
    t.illegal = 0; t.pc = 32'h404;
    run_trial(t, 0, 0, "msi_after");

    // Unwritten mtvec selects the reset vector.
    t = blank(); t.ecall = 1; t.pc = 32'h80; t.base = 32'h2000;
    run_trial(t, 1, 0, "reset_vec");

    // Mode 1 with a timer interrupt, then an ecall.
    t = blank(); t.mtip = 1; t.mie = 3'b010; t.en = 1; t.valid = 1; t.mode = 2'd1;
    t.pc = 32'h600; t.base = 32'h1000; t.mvalid = 1;
    run_trial(t, 0, 0, "mode1_mti");
    t = blank(); t.ecall = 1; t.mode = 2'd1; t.pc = 32'h604; t.base = 32'h1000; t.mvalid = 1;
    run_trial(t, 0, 0, "mode1_ecall");

    // External interrupt pulse through the synchroniser.
    apply(blank());
    ifc.mie_i = 3'b100; ifc.interrupt_en = 1; ifc.e2mif_valid = 1; ifc.e2mif_pc = 32'h500;
    ifc.mtvec_base = 32'h3000; ifc.mtvec_valid_i = 1; ifc.meip_i = 1;
    for (int i = 0; i < SYNC; i++) begin
      #1 check("mei.wait_hold", {31'd0, ifc.hold}, 32'd0);
      tick(); ifc.meip_i = 0;
    end
    #1 check("mei.detect_hold", {31'd0, ifc.hold}, 32'd1);
    tick(); ifc.e2mif_pc = 32'h504; #1;
    check("mei.exc", {31'd0, ifc.exception}, 32'd1);
    check("mei.cause", ifc.exception_cause, 32'h8000_000B);
    check("mei.epc", ifc.exception_pc, 32'h500);
    check("mei.target", ifc.exception_target, 32'h3000);
    tick(); #1;
    check("mei.after_exc", {31'd0, ifc.exception}, 32'd0);
    tick();

    // Reset while draining aborts the trap.
    t = blank(); t.illegal = 1; t.pc = 32'h300; t.base = 32'h800; t.mvalid = 1;
    apply(t); ifc.dmem_busy = 1; #1;
    check("rst.detect_hold", {31'd0, ifc.hold}, 32'd1);
    tick(); clear_events(0); #1;
    check("rst.drain_hold", {31'd0, ifc.hold}, 32'd1);
    #2 ifc.nRST = 0; #1;
    check_all_zero("rst.abort");
    tick(); ifc.dmem_busy = 0; tick();
    #2 ifc.nRST = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("rst.no_strobe", {31'd0, ifc.exception}, 32'd0);
      check("rst.idle_hold", {31'd0, ifc.hold}, 32'd0);
    end

    // Randomized trials.
    for (int n = 0; n < 60; n++) begin
      t.illegal = ($urandom_range(3) == 0);
      t.ebreak  = ($urandom_range(3) == 0);
      t.ecall   = ($urandom_range(3) == 0);
      t.msip    = $urandom_range(1) == 1;
      t.mtip    = $urandom_range(1) == 1;
      t.mie     = 3'($urandom_range(7));
      t.en      = ($urandom_range(3) != 0);
      t.valid   = ($urandom_range(3) != 0);
      t.mvalid  = ($urandom_range(3) != 0);
      t.mode    = 2'($urandom_range(3));
      t.pc      = $urandom & 32'hFFFF_FFFC;
      t.base    = ($urandom_range(3) == 0) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFC);
      run_trial(t, int'($urandom_range(3)), 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
